// File: rtl/lock_pkg.sv
// Shared types and defaults for the digital lock controller.
package lock_pkg;

  localparam int unsigned LOCK_DIGIT_W  = 2;
  localparam int unsigned LOCK_CODE_LEN = 3;
  localparam logic [LOCK_CODE_LEN*LOCK_DIGIT_W-1:0] LOCK_DEFAULT_CODE = 6'b01_10_11;

  typedef enum logic [2:0] {
    ENTRY,
    VERIFY,
    FAIL,
    OPEN,
    PROG,
    LOCKOUT
  } lock_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT states; holds at zero.
module lock_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Digital lock controller: code entry, verify, unlock window, lockout and re-programming.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN      = LOCK_CODE_LEN,
  parameter int unsigned DIGIT_W       = LOCK_DIGIT_W,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned UNLOCK_CYCLES = 500,
  parameter int unsigned LOCK_CYCLES   = 1000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  output logic [CODE_LEN-1:0] led_prog,
  output logic               clk_enb,
  output logic               unlocked,
  output logic               err,
  output logic               alarm,
  output logic               prog_active
);

  localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
  localparam int unsigned TIMER_W = $clog2(max_u(max_u(UNLOCK_CYCLES, LOCK_CYCLES), 2));
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned IDX_W   = $clog2(CODE_LEN + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0]  LAST_FAIL = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TIMER_W-1:0] T_UNLOCK  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_LOCK    = TIMER_W'(LOCK_CYCLES - 1);

  lock_state_t         state_q, state_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic [CODE_LEN-1:0] led_nxt;
  logic                mismatch_q, mismatch_nxt;
  logic [FAIL_W-1:0]   fail_q, fail_nxt;
  logic [CODE_W-1:0]   code_q, code_nxt;
  logic [CODE_W-1:0]   shadow_q, shadow_nxt, shadow_wr;
  logic [DIGIT_W-1:0]  cur_digit;
  logic [CODE_LEN-1:0] idx_hot;
  logic                enter_q;
  logic                press;
  logic                tmr_load, tmr_en, tmr_zero;
  logic [TIMER_W-1:0]  tmr_val;

  assign press = enter & ~enter_q;

  // Digit 0 lives in the MSBs, so slice i sits at offset (CODE_LEN-1-i).
  always_comb begin
    cur_digit = '0;
    shadow_wr = shadow_q;
    idx_hot   = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        shadow_wr[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
        idx_hot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state_q;
    idx_nxt      = idx_q;
    led_nxt      = led_prog;
    mismatch_nxt = mismatch_q;
    fail_nxt     = fail_q;
    code_nxt     = code_q;
    shadow_nxt   = shadow_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;

    case (state_q)
      ENTRY: begin
        if (press) begin
          mismatch_nxt = mismatch_q | (digit != cur_digit);
          led_nxt      = led_prog | idx_hot;
          idx_nxt      = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        idx_nxt      = '0;
        led_nxt      = '0;
        mismatch_nxt = 1'b0;
        if (!mismatch_q) begin
          state_nxt = OPEN;
          fail_nxt  = '0;
          tmr_load  = 1'b1;
          tmr_val   = T_UNLOCK;
        end else if (fail_q == LAST_FAIL) begin
          state_nxt = LOCKOUT;
          tmr_load  = 1'b1;
          tmr_val   = T_LOCK;
        end else begin
          fail_nxt  = fail_q + 1'b1;
          state_nxt = FAIL;
        end
      end
      FAIL: begin
        state_nxt = ENTRY;
      end
      OPEN: begin
        tmr_en = 1'b1;
        // Timer expiry takes priority over a coincident press.
        if (tmr_zero) begin
          state_nxt = ENTRY;
        end else if (press) begin
          if (mode) begin
            state_nxt = PROG;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = T_UNLOCK;
          end
        end
      end
      PROG: begin
        if (!mode) begin
          state_nxt = ENTRY;
          idx_nxt   = '0;
          led_nxt   = '0;
        end else if (press) begin
          shadow_nxt = shadow_wr;
          led_nxt    = led_prog | idx_hot;
          idx_nxt    = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            code_nxt  = shadow_wr;
            idx_nxt   = '0;
            led_nxt   = '0;
            state_nxt = ENTRY;
          end
        end
      end
      LOCKOUT: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_nxt = ENTRY;
          fail_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ENTRY;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      fail_q      <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
      enter_q     <= 1'b0;
      led_prog    <= '0;
      clk_enb     <= 1'b1;
      unlocked    <= 1'b0;
      err         <= 1'b0;
      alarm       <= 1'b0;
      prog_active <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      idx_q       <= idx_nxt;
      mismatch_q  <= mismatch_nxt;
      fail_q      <= fail_nxt;
      code_q      <= code_nxt;
      shadow_q    <= shadow_nxt;
      enter_q     <= enter;
      led_prog    <= led_nxt;
      clk_enb     <= (state_nxt == ENTRY) || (state_nxt == PROG);
      unlocked    <= (state_nxt == OPEN) || (state_nxt == PROG);
      err         <= (state_nxt == FAIL);
      alarm       <= (state_nxt == LOCKOUT);
      prog_active <= (state_nxt == PROG);
    end
  end

  lock_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .zero     (tmr_zero)
  );

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: attempts are scored by a code/fail-count model.
module tb_lock_sequencer;

  localparam int MAX_FAIL      = 3;
  localparam int UNLOCK_CYCLES = 500;
  localparam int LOCK_CYCLES   = 1000;

  localparam int EV_ERR   = 0;
  localparam int EV_OPEN  = 1;
  localparam int EV_ALARM = 2;

  logic       clk = 1'b0;
  logic       rst, mode, enter;
  logic [1:0] digit;
  logic [2:0] led_prog;
  logic       clk_enb, unlocked, err, alarm, prog_active;

  always #5 clk = ~clk;

  lock_sequencer #(
    .CODE_LEN      (3),
    .DIGIT_W       (2),
    .MAX_FAIL      (MAX_FAIL),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .LOCK_CYCLES   (LOCK_CYCLES),
    .DEFAULT_CODE  (6'b01_10_11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .digit       (digit),
    .enter       (enter),
    .led_prog    (led_prog),
    .clk_enb     (clk_enb),
    .unlocked    (unlocked),
    .err         (err),
    .alarm       (alarm),
    .prog_active (prog_active)
  );

  typedef struct {
    int kind;
    int width;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  code_m[3];
  int  fails_m;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: each completed output episode is matched against the next expected event.
  function automatic void report(input int kind, input int width);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d width %0d, expected none", kind, width);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.width != 0) check("event_width", width, e.width);
    end
  endfunction

  logic p_err = 1'b0, p_unl = 1'b0, p_alm = 1'b0;
  int   w_err = 0, w_unl = 0, w_alm = 0;

  always @(negedge clk) begin
    if (err === 1'b1)      w_err++;
    if (unlocked === 1'b1) w_unl++;
    if (alarm === 1'b1)    w_alm++;
    if (p_err && err === 1'b0)      begin report(EV_ERR, w_err);   w_err = 0; end
    if (p_unl && unlocked === 1'b0) begin report(EV_OPEN, w_unl);  w_unl = 0; end
    if (p_alm && alarm === 1'b0)    begin report(EV_ALARM, w_alm); w_alm = 0; end
    p_err = (err === 1'b1);
    p_unl = (unlocked === 1'b1);
    p_alm = (alarm === 1'b1);
  end

  // Reference model: outcome of a full entry from the stored code and failure count.
  function automatic int model_attempt(input int d0, input int d1, input int d2, input bit hold);
    ev_t e;
    if (d0 == code_m[0] && d1 == code_m[1] && d2 == code_m[2]) begin
      fails_m = 0;
      e.kind = EV_OPEN;
      e.width = hold ? 0 : UNLOCK_CYCLES;
    end else if (fails_m == MAX_FAIL - 1) begin
      fails_m = 0;
      e.kind = EV_ALARM;
      e.width = LOCK_CYCLES;
    end else begin
      fails_m++;
      e.kind = EV_ERR;
      e.width = 1;
    end
    exp_q.push_back(e);
    return e.kind;
  endfunction

  task automatic press(input int d, input int exp_led, input bit chk);
    @(posedge clk); #1;
    digit = 2'(d);
    enter = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (chk) check("led_prog", int'(led_prog), exp_led);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    enter = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (clk_enb && !unlocked && !alarm && !err) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    check("idle_reached", int'(ok), 1);
  endtask

  task automatic wait_level(input string name, input bit want_alarm);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (want_alarm ? alarm : unlocked) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic attempt(input int d0, input int d1, input int d2, input bit hold, input bit poke);
    int kind;
    press(d0, 1, 1'b1);
    press(d1, 3, 1'b1);
    kind = model_attempt(d0, d1, d2, hold);
    press(d2, 7, 1'b1);
    if (kind == EV_OPEN && hold) begin
      wait_level("unlock_seen", 1'b0);
    end else begin
      if (kind == EV_ALARM && poke) begin
        wait_level("alarm_seen", 1'b1);
        for (int k = 0; k < 3; k++) press(int'($urandom_range(0, 3)), 0, 1'b1);
      end
      wait_idle();
    end
  endtask

  task automatic program_code(input int n0, input int n1, input int n2, input bit abort);
    @(posedge clk); #1;
    mode = 1'b1;
    press(int'($urandom_range(0, 3)), 0, 1'b1);
    check("prog_active_on", int'(prog_active), 1);
    press(n0, 1, 1'b1);
    press(n1, 3, 1'b1);
    if (abort) begin
      @(posedge clk); #1;
      mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end else begin
      press(n2, 0, 1'b1);
      code_m = '{n0, n1, n2};
      @(posedge clk); #1;
      mode = 1'b0;
    end
    check("prog_active_off", int'(prog_active), 0);
    check("relocked", int'(unlocked), 0);
    check("led_after_prog", int'(led_prog), 0);
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_led_prog", int'(led_prog), 0);
    check("rst_clk_enb", int'(clk_enb), 1);
    code_m  = '{1, 2, 3};
    fails_m = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1; mode = 1'b0; enter = 1'b0; digit = 2'd0;
    code_m = '{1, 2, 3};
    fails_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led_prog", int'(led_prog), 0);
    check("rst_clk_enb", int'(clk_enb), 1);
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_err", int'(err), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_prog_active", int'(prog_active), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // correct code with explicit unlock latency
    press(1, 1, 1'b1);
    press(2, 3, 1'b1);
    void'(model_attempt(1, 2, 3, 1'b0));
    @(posedge clk); #1;
    digit = 2'd3;
    enter = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("led_prog", int'(led_prog), 7);
    check("unlock_early", int'(unlocked), 0);
    @(negedge clk);
    check("unlock_latency", int'(unlocked), 1);
    @(posedge clk); #1;
    enter = 1'b0;
    wait_idle();

    // wrong code, then lockout with ignored presses, then unlock
    attempt(1, 1, 3, 1'b0, 1'b0);
    check("led_after_err", int'(led_prog), 0);
    attempt(0, 0, 0, 1'b0, 1'b0);
    attempt(3, 3, 3, 1'b0, 1'b1);
    attempt(1, 2, 3, 1'b0, 1'b0);

    // reprogram to 3,0,2
    attempt(1, 2, 3, 1'b1, 1'b0);
    program_code(3, 0, 2, 1'b0);
    attempt(1, 2, 3, 1'b0, 1'b0);
    attempt(3, 0, 2, 1'b0, 1'b0);

    // reset mid-entry restores the default code
    press(3, 1, 1'b1);
    press(0, 3, 1'b1);
    do_reset();

    // programming abort keeps the old code
    attempt(1, 2, 3, 1'b1, 1'b0);
    program_code(2, 2, 0, 1'b1);
    attempt(1, 2, 3, 1'b0, 1'b0);

    // held enter captures exactly one digit
    @(posedge clk); #1;
    digit = 2'd1;
    enter = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("held_enter_led", int'(led_prog), 1);
    @(posedge clk); #1;
    enter = 1'b0;
    press(2, 3, 1'b1);
    void'(model_attempt(1, 2, 3, 1'b0));
    press(3, 7, 1'b1);
    wait_idle();

    // randomized phase
    for (int it = 0; it < 12; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        bit hold = 1'(int'($urandom_range(0, 1)));
        attempt(code_m[0], code_m[1], code_m[2], hold, 1'b0);
        if (hold)
          program_code(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), 1'(int'($urandom_range(0, 1))));
      end else if (r < 9) begin
        attempt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0, 1'(int'($urandom_range(0, 1))));
      end else begin
        press(int'($urandom_range(0, 3)), 1, 1'b1);
        do_reset();
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
